// File: rtl/fighter_kinematics.sv
// fighter_kinematics: per-player walk / jump / gravity / stomp integrator, advanced once per frame tick.
// Define FK_KNOCKBACK_EN to build the timed knockback (KNOCK) state with its counter and hit handling.
module fighter_kinematics #(
  parameter int X_W       = 7,
  parameter int Y_W       = 7,
  parameter int V_W       = 6,
  parameter int X_MIN     = 18,
  parameter int X_MAX     = 71,
  parameter int FLOOR_Y   = 48,
  parameter int CEIL_Y    = 18,
  parameter int START_X   = 18,
  parameter int STEP      = 2,
  parameter int JUMP_V    = 11,
  parameter int GRAVITY   = 1,
  parameter int VMAX_DOWN = 15,
  parameter int BOUNCE    = 3,
  parameter int KB_TICKS  = 6,
  parameter int KB_STEP   = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  tick,
  input  logic                  move_left,
  input  logic                  move_right,
  input  logic                  jump,
  input  logic                  hit,
  input  logic                  hit_from_right,
  input  logic                  colliding,
  input  logic [X_W-1:0]        opp_x,
  input  logic [Y_W-1:0]        opp_y,
  output logic [X_W-1:0]        pos_x,
  output logic [Y_W-1:0]        pos_y,
  output logic signed [V_W-1:0] vel_y,
  output logic [1:0]            state,
  output logic                  grounded
);

  // Two spare bits keep x-STEP below zero and y+vel overflow from wrapping before the clamps.
  localparam int IW   = ((X_W > Y_W) ? X_W : Y_W) + 2;
  localparam int KB_W = (KB_TICKS < 2) ? 1 : $clog2(KB_TICKS + 1);
  localparam logic [KB_W-1:0] KB_LOAD = KB_W'(KB_TICKS);

  localparam logic signed [IW-1:0] XMIN_S   = IW'(X_MIN);
  localparam logic signed [IW-1:0] XMAX_S   = IW'(X_MAX);
  localparam logic signed [IW-1:0] FLOOR_S  = IW'(FLOOR_Y);
  localparam logic signed [IW-1:0] CEIL_S   = IW'(CEIL_Y);
  localparam logic signed [IW-1:0] CEIL1_S  = IW'(CEIL_Y + 1);
  localparam logic signed [IW-1:0] VMAX_S   = IW'(VMAX_DOWN);
  localparam logic signed [IW-1:0] GRAV_S   = IW'(GRAVITY);
  localparam logic signed [IW-1:0] BOUNCE_S = IW'(BOUNCE);
  localparam logic signed [IW-1:0] STEP_S   = IW'(STEP);
  localparam logic signed [IW-1:0] KBSTEP_S = IW'(KB_STEP);

  typedef enum logic [1:0] {
    ST_GROUND = 2'd0,
    ST_AIR    = 2'd1,
    ST_KNOCK  = 2'd2
  } state_t;

  state_t                state_reg, state_next;
  logic [X_W-1:0]        x_reg, x_next;
  logic [Y_W-1:0]        y_reg, y_next;
  logic signed [V_W-1:0] vel_reg, vel_next;
  logic                  grounded_reg, grounded_next;

  logic signed [IW-1:0]  xs, ys, vs;
  logic signed [IW-1:0]  step_s, nx_s, ny_s, by_s, nv_s;
  logic                  go_left, go_right, knock_entry, in_knock;

  assign xs = signed'(IW'(x_reg));
  assign ys = signed'(IW'(y_reg));
  assign vs = IW'(vel_reg);

`ifdef FK_KNOCKBACK_EN
  logic [KB_W-1:0] kb_reg, kb_next;
  logic            dir_reg, dir_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      kb_reg  <= '0;
      dir_reg <= 1'b0;
    end else begin
      kb_reg  <= kb_next;
      dir_reg <= dir_next;
    end
  end
`else
  logic unused_kb;
  assign unused_kb = ^{hit, hit_from_right, KB_LOAD};
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= ST_GROUND;
      x_reg        <= X_W'(START_X);
      y_reg        <= Y_W'(FLOOR_Y);
      vel_reg      <= '0;
      grounded_reg <= 1'b1;
    end else begin
      state_reg    <= state_next;
      x_reg        <= x_next;
      y_reg        <= y_next;
      vel_reg      <= vel_next;
      grounded_reg <= grounded_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    x_next      = x_reg;
    y_next      = y_reg;
    vel_next    = vel_reg;
    go_left     = 1'b0;
    go_right    = 1'b0;
    step_s      = STEP_S;
    knock_entry = 1'b0;
    in_knock    = 1'b0;
    nx_s        = xs;
    ny_s        = ys + vs;
    by_s        = ys - BOUNCE_S;
    nv_s        = vs + GRAV_S;
`ifdef FK_KNOCKBACK_EN
    kb_next     = kb_reg;
    dir_next    = dir_reg;
    in_knock    = (state_reg == ST_KNOCK);
    knock_entry = tick && hit && (state_reg != ST_KNOCK);
`endif

    if (tick) begin
      // Knockback pushes away from the attacker; the entry tick itself does no walking.
      if (in_knock) begin
`ifdef FK_KNOCKBACK_EN
        go_left  = dir_reg;
        go_right = !dir_reg;
`endif
        step_s   = KBSTEP_S;
      end else if (!knock_entry) begin
        go_left  = move_left && !move_right;
        go_right = move_right && !move_left;
      end

      if (go_left && !(colliding && (x_reg > opp_x))) begin
        nx_s   = xs - step_s;
        x_next = (nx_s < XMIN_S) ? X_W'(X_MIN) : nx_s[X_W-1:0];
      end else if (go_right && !(colliding && (x_reg < opp_x))) begin
        nx_s   = xs + step_s;
        x_next = (nx_s > XMAX_S) ? X_W'(X_MAX) : nx_s[X_W-1:0];
      end

      if ((state_reg != ST_GROUND) && colliding && (y_reg < opp_y)) begin
        y_next   = (by_s < CEIL1_S) ? Y_W'(CEIL_Y + 1) : by_s[Y_W-1:0];
        vel_next = V_W'(1);
      end else if ((state_reg == ST_GROUND) && jump && !knock_entry) begin
        y_next     = Y_W'(FLOOR_Y - JUMP_V);
        vel_next   = V_W'(GRAVITY - JUMP_V);
        state_next = ST_AIR;
      end else if (state_reg != ST_GROUND) begin
        if (ny_s >= FLOOR_S) begin
          y_next   = Y_W'(FLOOR_Y);
          vel_next = '0;
          if (state_reg == ST_AIR) state_next = ST_GROUND;
        end else if (ny_s <= CEIL_S) begin
          y_next   = Y_W'(CEIL_Y + 1);
          vel_next = '0;
        end else begin
          y_next   = ny_s[Y_W-1:0];
          vel_next = (nv_s > VMAX_S) ? V_W'(VMAX_DOWN) : nv_s[V_W-1:0];
        end
      end

`ifdef FK_KNOCKBACK_EN
      if (knock_entry) begin
        state_next = ST_KNOCK;
        kb_next    = KB_LOAD;
        dir_next   = hit_from_right;
      end else if (in_knock) begin
        kb_next = kb_reg - KB_W'(1);
        if (kb_reg == KB_W'(1))
          state_next = (y_next == Y_W'(FLOOR_Y)) ? ST_GROUND : ST_AIR;
      end
`endif
    end

    grounded_next = (y_next == Y_W'(FLOOR_Y));
  end

  assign pos_x    = x_reg;
  assign pos_y    = y_reg;
  assign vel_y    = vel_reg;
  assign state    = state_reg;
  assign grounded = grounded_reg;

endmodule

// File: doc/fighter_kinematics.md
# fighter_kinematics

Parametrised per-player kinematics engine for the fighting game. Once per frame tick it integrates horizontal walking, a signed vertical velocity under gravity, floor and ceiling clamping, opponent collision blocking and stomp bounce, plus a timed knockback state. It sits between the player input decoder and the sprite renderer and collision detector, one instance per player.

## Interface
Parameters:
- X_W, 7, position width (x)
- Y_W, 7, position width (y); y grows downward
- V_W, 6, signed vertical velocity width; positive means down
- X_MIN, 18, left arena bound
- X_MAX, 71, right arena bound
- FLOOR_Y, 48, floor y
- CEIL_Y, 18, ceiling y
- START_X, 18, reset x
- STEP, 2, walk pixels per tick
- JUMP_V, 11, jump launch speed
- GRAVITY, 1, velocity increment per tick
- VMAX_DOWN, 15, terminal fall speed
- BOUNCE, 3, stomp lift in pixels
- KB_TICKS, 6, knockback duration in ticks
- KB_STEP, 3, knockback pixels per tick

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- tick  in  1  frame strobe (20 Hz); the state advances only on cycles with tick=1
- move_left / move_right  in  1  walk requests
- jump  in  1  jump request, sampled on tick
- hit  in  1  knockback request, sampled on tick
- hit_from_right  in  1  attacker is on the right; push goes left
- colliding  in  1  hitboxes overlap
- opp_x  in  X_W  opponent x
- opp_y  in  Y_W  opponent y
- pos_x  out  X_W  sprite x
- pos_y  out  Y_W  sprite y
- vel_y  out  V_W  signed vertical velocity
- state  out  2  0=GROUND, 1=AIR, 2=KNOCK
- grounded  out  1  pos_y==FLOOR_Y

## Operation
- Reset sets pos_x=START_X, pos_y=FLOOR_Y, vel_y=0, state=GROUND, grounded=1, kb counter=0.
- Horizontal motion in GROUND and AIR:
  - move_left alone: x-=STEP, clamped to X_MIN. Blocked when colliding && pos_x>opp_x.
  - move_right alone: x+=STEP, clamped to X_MAX. Blocked when colliding && pos_x<opp_x.
  - Both asserted, or neither: no move.
- Vertical priority on each tick, highest first:
  1. Stomp: state!=GROUND && colliding && pos_y<opp_y. Set y=max(y-BOUNCE, CEIL_Y+1) and vel_y=+1.
  2. Jump: state==GROUND && jump. Set y=FLOOR_Y-JUMP_V, vel_y=-JUMP_V+GRAVITY, state→AIR.
  3. Airborne integrate, computing ny=y+vel_y:
     - ny>=FLOOR_Y: y=FLOOR_Y, vel_y=0, state→GROUND.
     - ny<=CEIL_Y: y=CEIL_Y+1, vel_y=0.
     - Otherwise: y=ny, vel_y=min(vel_y+GRAVITY, VMAX_DOWN).
- Leaving the floor without a jump is impossible; GROUND always has vel_y=0.
- KNOCK state (macro-gated):
  - Entry: hit on a tick while state!=KNOCK. Load kb counter=KB_TICKS and latch the push direction from hit_from_right.
  - Each tick in KNOCK: x moves KB_STEP away from the attacker, clamped to the bounds; collision blocking still applies. Walk and jump inputs are ignored. Vertical integration (rules 1 and 3) continues. Decrement the counter.
  - Exit: on the tick the counter reaches 0, state→GROUND if y==FLOOR_Y, else AIR.
  - A hit during KNOCK is ignored and does not re-arm the counter.
- Arithmetic uses signed intermediates of max(X_W,Y_W)+2 bits, so subtraction below 0 and overflow never wrap before clamping.

## Timing
- All outputs are registered. An update becomes visible on the clk edge following a cycle with tick=1; outputs hold between ticks.
- Inputs are sampled only on tick cycles; pulses between ticks are lost. This is intended.
- Reset overrides tick and takes effect mid-jump or mid-knockback; there is no residual velocity.
- grounded is registered together with pos_y, with no extra cycle.

## Configuration
- FK_KNOCKBACK_EN defined: KNOCK state, kb counter and hit handling are present.
- FK_KNOCKBACK_EN undefined: hit and hit_from_right are ignored, state never equals 2, and the counter logic is removed.

## Test plan
- Reset, then 3 ticks with no input → pos=(18,48), vel_y=0, state=GROUND.
- jump on tick 0 with defaults → y: 37,27,19,19,20,22,25,29,34,40,47,48. GROUND on tick 11, vel_y=0.
- move_right held 30 ticks from x=18 → x rises by 2 per tick and saturates at 71, never 72 or more. Both directions held → x unchanged.
- colliding=1, opp_x=40, pos_x=38, move_right → x stays 38. move_left → 36.
- Airborne at y=30, opp_y=40, colliding → y=27, vel_y=+1. Next tick y=28.
- With FK_KNOCKBACK_EN: hit, hit_from_right=1, x=30 → x 27,24,21,18,18,18 over 6 ticks, then GROUND. A second hit mid-knockback does not extend it. Without the macro: x stays 30.
